// File: rtl/regfile_2r1w_sb.sv
// Parametrised 2-read/1-write register file with pending-write scoreboard.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_2r1w_sb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             reserve,
  input  logic [AW-1:0]    reservenum,
  output logic             err
);

  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pend_nxt;
  logic             err_nxt;

  logic wr_ok;
  logic rs_ok;
  logic ra_ok;
  logic rb_ok;

  // Index range qualification; out-of-range requests are dropped.
  always_comb begin
    wr_ok = write   && ({1'b0, writenum}   < LIM);
    rs_ok = reserve && ({1'b0, reservenum} < LIM);
    ra_ok = {1'b0, readnum_a} < LIM;
    rb_ok = {1'b0, readnum_b} < LIM;
  end

  // Scoreboard next state: write clears, reserve sets (reserve wins).
  always_comb begin
    pend_nxt = pending;
    if (wr_ok) pend_nxt[writenum] = 1'b0;
    if (rs_ok) pend_nxt[reservenum] = 1'b1;
  end

  // Double reservation, unless the same-cycle write retires it.
  always_comb begin
    err_nxt = 1'b0;
    if (rs_ok && pending[reservenum])
      err_nxt = !(wr_ok && (writenum == reservenum));
  end

  // Array, scoreboard and error pulse; reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      if (wr_ok) mem[writenum] <= data_in;
      pending <= pend_nxt;
      err     <= err_nxt;
    end
  end

  // Port A combinational read.
  always_comb begin
    data_out_a = '0;
    busy_a     = 1'b0;
    if (ra_ok) begin
      data_out_a = mem[readnum_a];
      busy_a     = pending[readnum_a];
`ifdef REGFILE_BYPASS_EN
      if (reset_n && wr_ok && (writenum == readnum_a)) begin
        data_out_a = data_in;
        busy_a     = rs_ok && (reservenum == readnum_a);
      end
`endif
    end
  end

  // Port B combinational read.
  always_comb begin
    data_out_b = '0;
    busy_b     = 1'b0;
    if (rb_ok) begin
      data_out_b = mem[readnum_b];
      busy_b     = pending[readnum_b];
`ifdef REGFILE_BYPASS_EN
      if (reset_n && wr_ok && (writenum == readnum_b)) begin
        data_out_b = data_in;
        busy_b     = rs_ok && (reservenum == readnum_b);
      end
`endif
    end
  end

endmodule
